// File: rtl/tile_addr_gen.sv
// TileGroup descriptor expander: one region request per row, one row per cycle.
// Optional build macro TILE_ADDR_GEN_COALESCE_EN merges contiguous rows into one request.
module tile_addr_gen #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 32,
    parameter int GID_WIDTH  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  desc_valid_i,
    output logic                  desc_ready_o,
    input  logic [ADDR_WIDTH-1:0] desc_base_i,
    input  logic [LEN_WIDTH-1:0]  desc_row_len_i,
    input  logic [ADDR_WIDTH-1:0] desc_stride_i,
    input  logic [CNT_WIDTH-1:0]  desc_rows_i,
    input  logic [GID_WIDTH-1:0]  desc_gid_i,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    output logic [ADDR_WIDTH-1:0] req_base_o,
    output logic [LEN_WIDTH-1:0]  req_len_o,
    output logic [GID_WIDTH-1:0]  req_gid_o,
    output logic                  busy_o,
    output logic                  done_pulse_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_GEN  = 1'b1
    } state_e;

    state_e                  state_q;
    logic                    desc_ready_q;
    logic                    req_valid_q;
    logic [ADDR_WIDTH-1:0]   req_base_q;
    logic [LEN_WIDTH-1:0]    req_len_q;
    logic [GID_WIDTH-1:0]    req_gid_q;
    logic                    busy_q;
    logic                    done_q;
    logic [ADDR_WIDTH-1:0]   stride_q;
    logic [CNT_WIDTH-1:0]    rows_q;
    logic [CNT_WIDTH-1:0]    row_cnt_q;

    logic                    desc_fire_s;
    logic                    req_fire_s;
    logic                    last_row_s;
    logic [ADDR_WIDTH-1:0]   base_d;
    logic [LEN_WIDTH-1:0]    first_len_d;
    logic [CNT_WIDTH-1:0]    first_rows_d;

    assign desc_fire_s = desc_valid_i & desc_ready_q;
    assign req_fire_s  = req_valid_q & req_ready_i;
    assign last_row_s  = (row_cnt_q == (rows_q - CNT_WIDTH'(1)));
    // Row addresses wrap modulo 2^ADDR_WIDTH by plain truncation.
    assign base_d      = req_base_q + stride_q;

`ifdef TILE_ADDR_GEN_COALESCE_EN
    localparam int PROD_WIDTH = LEN_WIDTH + CNT_WIDTH;
    localparam int CMP_WIDTH  = (ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH;

    logic [PROD_WIDTH-1:0] prod_s;
    logic                  coalesce_s;

    assign prod_s     = PROD_WIDTH'(desc_row_len_i) * PROD_WIDTH'(desc_rows_i);
    assign coalesce_s = (CMP_WIDTH'(desc_stride_i) == CMP_WIDTH'(desc_row_len_i))
                     && (desc_rows_i != {CNT_WIDTH{1'b0}})
                     && (prod_s[PROD_WIDTH-1:LEN_WIDTH] == {CNT_WIDTH{1'b0}});

    // Contiguous descriptor collapses into a single one-row request.
    always_comb begin
        first_len_d  = desc_row_len_i;
        first_rows_d = desc_rows_i;
        if (coalesce_s) begin
            first_len_d  = prod_s[LEN_WIDTH-1:0];
            first_rows_d = CNT_WIDTH'(1);
        end else begin
            first_len_d  = desc_row_len_i;
            first_rows_d = desc_rows_i;
        end
    end
`else
    // Without coalescing every row is emitted on its own.
    always_comb begin
        first_len_d  = desc_row_len_i;
        first_rows_d = desc_rows_i;
    end
`endif

    // Descriptor FSM with all outputs registered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            desc_ready_q <= 1'b1;
            req_valid_q  <= 1'b0;
            req_base_q   <= {ADDR_WIDTH{1'b0}};
            req_len_q    <= {LEN_WIDTH{1'b0}};
            req_gid_q    <= {GID_WIDTH{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            stride_q     <= {ADDR_WIDTH{1'b0}};
            rows_q       <= {CNT_WIDTH{1'b0}};
            row_cnt_q    <= {CNT_WIDTH{1'b0}};
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (desc_fire_s) begin
                        stride_q <= desc_stride_i;
                        if (desc_rows_i == {CNT_WIDTH{1'b0}}) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q      <= ST_GEN;
                            desc_ready_q <= 1'b0;
                            busy_q       <= 1'b1;
                            req_valid_q  <= 1'b1;
                            req_base_q   <= desc_base_i;
                            req_len_q    <= first_len_d;
                            req_gid_q    <= desc_gid_i;
                            rows_q       <= first_rows_d;
                            row_cnt_q    <= {CNT_WIDTH{1'b0}};
                        end
                    end
                end
                ST_GEN: begin
                    // Request fields stay frozen until the downstream takes them.
                    if (req_fire_s) begin
                        if (last_row_s) begin
                            state_q      <= ST_IDLE;
                            req_valid_q  <= 1'b0;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                            desc_ready_q <= 1'b1;
                        end else begin
                            req_base_q <= base_d;
                            row_cnt_q  <= row_cnt_q + CNT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    desc_ready_q <= 1'b1;
                    req_valid_q  <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign desc_ready_o = desc_ready_q;
    assign req_valid_o  = req_valid_q;
    assign req_base_o   = req_base_q;
    assign req_len_o    = req_len_q;
    assign req_gid_o    = req_gid_q;
    assign busy_o       = busy_q;
    assign done_pulse_o = done_q;

endmodule

// File: tb/tb_tile_addr_gen.sv
// Randomized bench for tile_addr_gen: each descriptor is expanded by an arithmetic
// reference model into an expected request list and checked cycle by cycle.
module tb_tile_addr_gen;

`ifdef TILE_ADDR_GEN_COALESCE_EN
    localparam bit COALESCE = 1'b1;
`else
    localparam bit COALESCE = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        desc_valid_i;
    logic        desc_ready_o;
    logic [31:0] desc_base_i;
    logic [31:0] desc_row_len_i;
    logic [31:0] desc_stride_i;
    logic [15:0] desc_rows_i;
    logic [15:0] desc_gid_i;
    logic        req_valid_o;
    logic        req_ready_i;
    logic [31:0] req_base_o;
    logic [31:0] req_len_o;
    logic [15:0] req_gid_o;
    logic        busy_o;
    logic        done_pulse_o;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_base[$];
    logic [31:0] exp_len[$];

    tile_addr_gen dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
        .desc_base_i(desc_base_i), .desc_row_len_i(desc_row_len_i),
        .desc_stride_i(desc_stride_i), .desc_rows_i(desc_rows_i),
        .desc_gid_i(desc_gid_i),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .req_base_o(req_base_o), .req_len_o(req_len_o), .req_gid_o(req_gid_o),
        .busy_o(busy_o), .done_pulse_o(done_pulse_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: list of regions a descriptor must produce.
    task automatic build_exp(input logic [31:0] base, input logic [31:0] len,
                             input logic [31:0] stride, input logic [15:0] rows);
        logic [63:0] prod;
        logic [63:0] addr;
        exp_base.delete();
        exp_len.delete();
        prod = 64'(len) * 64'(rows);
        if (COALESCE && stride == len && rows != 16'd0 && prod < 64'h1_0000_0000) begin
            exp_base.push_back(base);
            exp_len.push_back(prod[31:0]);
        end else begin
            for (int i = 0; i < int'(rows); i++) begin
                addr = 64'(base) + 64'(stride) * 64'(i);
                exp_base.push_back(addr[31:0]);
                exp_len.push_back(len);
            end
        end
    endtask

    // Issue one descriptor at a falling edge and follow it to its done pulse.
    task automatic run_desc(input logic [31:0] base, input logic [31:0] len,
                            input logic [31:0] stride, input logic [15:0] rows,
                            input logic [15:0] gid, input int stall_pct,
                            input int stall_idx, input int stall_n);
        int idx;
        int stalled;
        int cycles;
        logic rdy;
        chk("idle_desc_ready", desc_ready_o, 1);
        chk("idle_req_valid", req_valid_o, 0);
        chk("idle_busy", busy_o, 0);
        desc_base_i = base;
        desc_row_len_i = len;
        desc_stride_i = stride;
        desc_rows_i = rows;
        desc_gid_i = gid;
        desc_valid_i = 1'b1;
        req_ready_i = 1'b1;
        build_exp(base, len, stride, rows);
        @(negedge clk_i);
        desc_valid_i = 1'b0;
        idx = 0;
        stalled = 0;
        cycles = 0;
        while (idx < exp_base.size()) begin
            chk("req_valid", req_valid_o, 1);
            chk("req_base", req_base_o, exp_base[idx]);
            chk("req_len", req_len_o, exp_len[idx]);
            chk("req_gid", req_gid_o, gid);
            chk("gen_busy", busy_o, 1);
            chk("gen_desc_ready", desc_ready_o, 0);
            chk("gen_done", done_pulse_o, 0);
            if (idx == stall_idx && stalled < stall_n) begin
                rdy = 1'b0;
                stalled++;
            end else begin
                rdy = ($urandom_range(99) >= stall_pct);
            end
            req_ready_i = rdy;
            desc_valid_i = !(rdy && idx == exp_base.size() - 1) && ($urandom_range(1) == 1);
            desc_base_i = $urandom;
            desc_row_len_i = $urandom;
            desc_stride_i = $urandom;
            desc_rows_i = 16'($urandom_range(1, 9));
            desc_gid_i = 16'($urandom);
            if (rdy) idx++;
            cycles++;
            @(negedge clk_i);
            if (cycles > 2000) begin
                chk("gen_cycle_budget", 64'(cycles), 64'd0);
                break;
            end
        end
        desc_valid_i = 1'b0;
        chk("done_pulse", done_pulse_o, 1);
        chk("done_req_valid", req_valid_o, 0);
        chk("done_busy", busy_o, 0);
        chk("done_desc_ready", desc_ready_o, 1);
        @(negedge clk_i);
        chk("done_one_cycle", done_pulse_o, 0);
    endtask

    initial begin
        logic [31:0] len;
        logic [31:0] stride;
        rst_i = 1'b1;
        desc_valid_i = 1'b0;
        desc_base_i = 32'd0;
        desc_row_len_i = 32'd0;
        desc_stride_i = 32'd0;
        desc_rows_i = 16'd0;
        desc_gid_i = 16'd0;
        req_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_desc_ready", desc_ready_o, 1);
        chk("rst_req_valid", req_valid_o, 0);
        chk("rst_req_base", req_base_o, 0);
        chk("rst_req_len", req_len_o, 0);
        chk("rst_req_gid", req_gid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_pulse_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);

        run_desc(32'h0000_1000, 32'd64, 32'h100, 16'd3, 16'd5, 0, -1, 0);
        run_desc(32'h0000_1000, 32'd64, 32'h100, 16'd3, 16'd5, 0, 1, 2);
        run_desc(32'h0000_0040, 32'd64, 32'h100, 16'd0, 16'd9, 0, -1, 0);
        run_desc(32'hFFFF_FF00, 32'd16, 32'h100, 16'd2, 16'd3, 0, -1, 0);
        run_desc(32'h0000_2000, 32'd128, 32'd128, 16'd4, 16'd7, 0, -1, 0);
        run_desc(32'h0000_3000, 32'hF000_0000, 32'hF000_0000, 16'd2, 16'd1, 0, -1, 0);
        run_desc(32'h0000_3000, 32'd8, 32'd0, 16'd3, 16'd2, 0, -1, 0);
        run_desc(32'h0000_4000, 32'd0, 32'h40, 16'd2, 16'd4, 0, -1, 0);

        // Reset while row 1 of a 4-row descriptor is presented.
        desc_base_i = 32'h0000_5000;
        desc_row_len_i = 32'd32;
        desc_stride_i = 32'h80;
        desc_rows_i = 16'd4;
        desc_gid_i = 16'd11;
        desc_valid_i = 1'b1;
        req_ready_i = 1'b1;
        @(negedge clk_i);
        desc_valid_i = 1'b0;
        chk("rstmid_row0", req_base_o, 32'h0000_5000);
        @(negedge clk_i);
        chk("rstmid_row1", req_base_o, 32'h0000_5080);
        rst_i = 1'b1;
        #1;
        chk("rstmid_req_valid", req_valid_o, 0);
        chk("rstmid_busy", busy_o, 0);
        chk("rstmid_desc_ready", desc_ready_o, 1);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("rstmid_no_req", req_valid_o, 0);
            chk("rstmid_no_done", done_pulse_o, 0);
            chk("rstmid_ready_after", desc_ready_o, 1);
        end

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(3))
                0: len = 32'd0;
                1: len = 32'($urandom_range(1, 4096));
                2: len = $urandom;
                default: len = 32'd256;
            endcase
            stride = ($urandom_range(2) == 0) ? len : $urandom;
            run_desc($urandom, len, stride, 16'($urandom_range(0, 6)), 16'($urandom),
                     $urandom_range(0, 40), -1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
